traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Six-phase traffic-light controller for a main/side intersection. It drives the load/down interface of the countdown timer and reacts when that timer reaches zero. It holds main-street green until a side-street vehicle or pedestrian request is pending. It then cycles yellow, all-red, side green (with optional walk), side yellow and all-red, and returns to main green.

## Interface
- COUNT_SIZE, 7, width of timer load value and timer count
- MAIN_MIN, 30, minimum main-green duration in timer ticks
- SIDE_TIME, 20, side-green duration
- YELLOW_TIME, 4, yellow duration (both directions)
- ALLRED_TIME, 2, all-red clearance duration
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- car_waiting  in  1  side-street vehicle sensor, level, sampled each cycle
- ped_request  in  1  pedestrian button, sampled each cycle, latched
- tmr_count  in  COUNT_SIZE  current value of the countdown timer
- tmr_load  out  1  load strobe to timer
- tmr_load_val  out  COUNT_SIZE  duration for the phase being entered
- tmr_down  out  1  decrement enable to timer
- main_light  out  3  {red, yellow, green}, one-hot
- side_light  out  3  {red, yellow, green}, one-hot
- walk  out  1  pedestrian walk indication
- phase  out  3  state encoding, for debug

## Operation
- States and encodings:
  - MAIN_GREEN=0
  - MAIN_YELLOW=1
  - ALLRED_A=2
  - SIDE_GREEN=3
  - SIDE_YELLOW=4
  - ALLRED_B=5
  - Encodings 6 and 7 are illegal; they go to ALLRED_B with the entry flag set.
- Registered entry flag `entry`. It is set on every state change and cleared one cycle later.
  - While entry=1: tmr_load=1, tmr_down=0, tmr_load_val = duration of the current state.
  - While entry=0: tmr_load=0, tmr_down=1.
- Durations per state:
  - MAIN_GREEN: MAIN_MIN
  - SIDE_GREEN: SIDE_TIME
  - Yellows: YELLOW_TIME
  - All-reds: ALLRED_TIME
- Expiry = (entry==0) && (tmr_count==0). The entry guard masks the stale count seen during the load cycle.
- Transitions, taken on the edge after expiry:
  - MAIN_GREEN → MAIN_YELLOW only if car_waiting or ped_pending. Otherwise stay in MAIN_GREEN with no reload; tmr_down stays 1 and the timer saturates at 0. The yellow is then entered on the first cycle a request is present.
  - MAIN_YELLOW → ALLRED_A → SIDE_GREEN → SIDE_YELLOW → ALLRED_B → MAIN_GREEN, each unconditionally on expiry.
- ped_pending register:
  - Set by ped_request in any cycle.
  - Cleared on the edge entering SIDE_GREEN.
  - Set has priority over clear. A press on the entry edge is served by this walk and also leaves ped_pending=1 for the next cycle.
- walk register:
  - Loaded on the SIDE_GREEN entry edge with ped_pending|ped_request.
  - Cleared on the edge leaving SIDE_GREEN.
  - Never 1 outside SIDE_GREEN.
- Lights, decoded from state:
  - main_light: green (001) in MAIN_GREEN, yellow (010) in MAIN_YELLOW, red (100) otherwise.
  - side_light: green in SIDE_GREEN, yellow in SIDE_YELLOW, red otherwise.
- Safety invariant: main_light and side_light are never both non-red.
- Widths: every duration parameter must be ≤ 2^COUNT_SIZE−1. tmr_load_val is the parameter truncated to COUNT_SIZE bits.

## Timing
- Reset (rst=0), asynchronous:
  - state=ALLRED_B, entry=1, ped_pending=0, walk=0.
  - Outputs during reset: main_light=100, side_light=100, walk=0, tmr_load=1, tmr_load_val=ALLRED_TIME, tmr_down=0, phase=5.
- Timer contract: the timer registers the load on the edge ending the entry cycle. It decrements once per edge while tmr_down=1 and saturates at 0.
- A phase of duration N with no hold occupies exactly N+2 cycles: 1 load cycle, N decrement cycles, and 1 cycle observing 0.
- Duration 0 gives 2 cycles.
- Minimum full cycle, with requests present at main-green expiry: MAIN_MIN + SIDE_TIME + 2·YELLOW_TIME + 2·ALLRED_TIME + 12 cycles.
- Reset asserted mid-phase returns immediately to the reset state. Timer and lights are red within the same cycle; no yellow is forced.
- Request inputs have one-cycle registered latency into ped_pending. car_waiting is used combinationally at expiry.

## Test plan
1. Reset with defaults, then release; no requests → ALLRED_B lasts 4 cycles, then MAIN_GREEN for ≥32 cycles. With no requests, MAIN_GREEN holds for 200 cycles and tmr_load pulses exactly once.
2. car_waiting=1 constant → sequence lengths 32, 6, 4, 22, 6, 4 cycles. Lights never both non-red. walk stays 0.
3. Single-cycle ped_request pulse during MAIN_GREEN with car_waiting=0 → yellow follows expiry. walk=1 for all 22 SIDE_GREEN cycles. ped_pending=0 afterwards.
4. ped_request pulsed exactly on the SIDE_GREEN entry edge → walk=1 in this SIDE_GREEN. The next main-green expiry still goes to yellow because of the retained pending request.
5. rst asserted in the middle of SIDE_GREEN, with walk=1 and tmr_count=9 → same cycle: walk=0, both lights 100, tmr_load=1 with value 2. After release, normal ALLRED_B timing resumes.
6. ALLRED_TIME=0, YELLOW_TIME=1, COUNT_SIZE=3 → all-red phases last 2 cycles, yellows last 3. No entry-cycle false expiry when tmr_count starts at 0.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Six-phase main/side traffic controller driving a load/down countdown timer.
// Holds main green until a side vehicle or pedestrian request is pending.
module traffic_phase_sequencer #(
  parameter int COUNT_SIZE  = 7,
  parameter int MAIN_MIN    = 30,
  parameter int SIDE_TIME   = 20,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  car_waiting,
  input  logic                  ped_request,
  input  logic [COUNT_SIZE-1:0] tmr_count,
  output logic                  tmr_load,
  output logic [COUNT_SIZE-1:0] tmr_load_val,
  output logic                  tmr_down,
  output logic [2:0]            main_light,
  output logic [2:0]            side_light,
  output logic                  walk,
  output logic [2:0]            phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5
  } state_t;

  localparam logic [COUNT_SIZE-1:0] MAIN_V   = COUNT_SIZE'(MAIN_MIN);
  localparam logic [COUNT_SIZE-1:0] SIDE_V   = COUNT_SIZE'(SIDE_TIME);
  localparam logic [COUNT_SIZE-1:0] YELLOW_V = COUNT_SIZE'(YELLOW_TIME);
  localparam logic [COUNT_SIZE-1:0] ALLRED_V = COUNT_SIZE'(ALLRED_TIME);

  state_t state;
  state_t nxt;
  logic   entry;
  logic   ped_pending;
  logic   walk_q;
  logic   expiry;
  logic   enter_side;
  logic   leave_side;

  // the load cycle still shows the previous phase's zero, so mask it
  assign expiry     = !entry && (tmr_count == '0);
  assign enter_side = (nxt == SIDE_GREEN) && (state != SIDE_GREEN);
  assign leave_side = (state == SIDE_GREEN) && (nxt != SIDE_GREEN);

  // next phase: main green waits for a request, the rest advance on expiry
  always_comb begin
    nxt = state;
    case (state)
      MAIN_GREEN:
        if (expiry && (car_waiting || ped_pending)) nxt = MAIN_YELLOW;
      MAIN_YELLOW: if (expiry) nxt = ALLRED_A;
      ALLRED_A:    if (expiry) nxt = SIDE_GREEN;
      SIDE_GREEN:  if (expiry) nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (expiry) nxt = ALLRED_B;
      ALLRED_B:    if (expiry) nxt = MAIN_GREEN;
      default:     nxt = ALLRED_B;
    endcase
  end

  // phase, entry flag, pending pedestrian request and walk registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ALLRED_B;
      entry       <= 1'b1;
      ped_pending <= 1'b0;
      walk_q      <= 1'b0;
    end else begin
      state <= nxt;
      entry <= (nxt != state);
      if (ped_request)
        ped_pending <= 1'b1;
      else if (enter_side)
        ped_pending <= 1'b0;
      if (enter_side)
        walk_q <= ped_pending | ped_request;
      else if (leave_side || state != SIDE_GREEN)
        walk_q <= 1'b0;
    end
  end

  // timer handshake and light decode from the registered phase
  always_comb begin
    tmr_load     = entry;
    tmr_down     = !entry;
    tmr_load_val = ALLRED_V;
    main_light   = 3'b100;
    side_light   = 3'b100;
    case (state)
      MAIN_GREEN:  begin tmr_load_val = MAIN_V;   main_light = 3'b001; end
      MAIN_YELLOW: begin tmr_load_val = YELLOW_V; main_light = 3'b010; end
      SIDE_GREEN:  begin tmr_load_val = SIDE_V;   side_light = 3'b001; end
      SIDE_YELLOW: begin tmr_load_val = YELLOW_V; side_light = 3'b010; end
      default:     tmr_load_val = ALLRED_V;
    endcase
  end

  assign walk  = walk_q;
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a behavioural countdown
// timer per instance; default parameters plus a short-duration variant.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       car = 1'b0;
  logic       ped = 1'b0;
  logic [6:0] tcnt = '0;
  logic       tload;
  logic [6:0] tval;
  logic       tdown;
  logic [2:0] ml;
  logic [2:0] sl;
  logic       walk;
  logic [2:0] phase;

  logic       rst2 = 1'b0;
  logic       car2 = 1'b0;
  logic       ped2 = 1'b0;
  logic [2:0] tcnt2 = '0;
  logic       tload2;
  logic [2:0] tval2;
  logic       tdown2;
  logic [2:0] ml2;
  logic [2:0] sl2;
  logic       walk2;
  logic [2:0] phase2;

  int checks = 0;
  int failures = 0;
  int unsafe = 0;
  int walk_bad = 0;

  always #5 clk = ~clk;

  traffic_phase_sequencer dut (
    .clk(clk), .rst(rst), .car_waiting(car), .ped_request(ped),
    .tmr_count(tcnt), .tmr_load(tload), .tmr_load_val(tval),
    .tmr_down(tdown), .main_light(ml), .side_light(sl),
    .walk(walk), .phase(phase)
  );

  traffic_phase_sequencer #(
    .COUNT_SIZE(3), .MAIN_MIN(5), .SIDE_TIME(3),
    .YELLOW_TIME(1), .ALLRED_TIME(0)
  ) u2 (
    .clk(clk), .rst(rst2), .car_waiting(car2), .ped_request(ped2),
    .tmr_count(tcnt2), .tmr_load(tload2), .tmr_load_val(tval2),
    .tmr_down(tdown2), .main_light(ml2), .side_light(sl2),
    .walk(walk2), .phase(phase2)
  );

  // countdown timer models following the load/down contract
  always @(posedge clk) begin
    if (tload) tcnt <= tval;
    else if (tdown && tcnt != 0) tcnt <= tcnt - 7'd1;
    if (tload2) tcnt2 <= tval2;
    else if (tdown2 && tcnt2 != 0) tcnt2 <= tcnt2 - 3'd1;
  end

  // continuous safety monitors
  always @(negedge clk) begin
    if (ml != 3'b100 && sl != 3'b100) unsafe++;
    if (ml2 != 3'b100 && sl2 != 3'b100) unsafe++;
    if (walk && phase != 3'd3) walk_bad++;
    if (walk2) walk_bad++;
  end

  // cycles spent in the current phase (bounded), main instance
  task automatic run_phase(output int len);
    logic [2:0] p0;
    p0 = phase;
    len = 0;
    while (phase == p0 && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic run_phase2(output int len);
    logic [2:0] p0;
    p0 = phase2;
    len = 0;
    while (phase2 == p0 && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p, output int n);
    n = 0;
    while (phase != p && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ml, sl, walk, tload, tval, tdown, phase} !==
        {3'b100, 3'b100, 1'b0, 1'b1, 7'd2, 1'b0, 3'd5}) begin
      failures++;
      $display("FAIL reset_outputs ml=%b sl=%b walk=%b ld=%b val=%0d dn=%b ph=%0d",
               ml, sl, walk, tload, tval, tdown, phase);
    end
  endtask

  task automatic test_idle_hold;
    int len;
    int loads;
    int moved;
    rst = 1'b1;
    run_phase(len);
    checks++;
    if (len !== 4) begin
      failures++;
      $display("FAIL allred_b_after_reset len=%0d want 4", len);
    end
    checks++;
    if (phase !== 3'd0) begin
      failures++;
      $display("FAIL enter_main_green phase=%0d want 0", phase);
    end
    loads = 0;
    moved = 0;
    for (int i = 0; i < 200; i++) begin
      if (tload) loads++;
      if (phase != 3'd0) moved++;
      @(negedge clk);
    end
    checks++;
    if (moved !== 0) begin
      failures++;
      $display("FAIL idle_hold left_cycles=%0d want 0", moved);
    end
    checks++;
    if (loads !== 1) begin
      failures++;
      $display("FAIL idle_load_pulses got=%0d want 1", loads);
    end
    checks++;
    if (tcnt !== 7'd0 || tdown !== 1'b1) begin
      failures++;
      $display("FAIL idle_saturate cnt=%0d down=%b want 0/1", tcnt, tdown);
    end
  endtask

  task automatic test_car_cycle;
    int n;
    int len;
    int exp_len[6];
    int w0;
    exp_len = '{6, 4, 22, 6, 4, 32};
    w0 = walk_bad;
    car = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 3'd1) begin
      failures++;
      $display("FAIL car_immediate_yellow phase=%0d want 1", phase);
    end
    for (int i = 0; i < 6; i++) begin
      run_phase(len);
      checks++;
      if (len !== exp_len[i]) begin
        failures++;
        $display("FAIL car_phase_len idx=%0d got=%0d want %0d", i, len, exp_len[i]);
      end
    end
    car = 1'b0;
    checks++;
    if (walk_bad !== w0) begin
      failures++;
      $display("FAIL car_walk got=%0d want 0", walk_bad - w0);
    end
    wait_phase(3'd0, n);
    checks++;
    if (phase !== 3'd0) begin
      failures++;
      $display("FAIL car_return_main phase=%0d want 0", phase);
    end
  endtask

  task automatic test_ped_pulse;
    int len;
    int wl;
    int moved;
    len = 0;
    while (phase == 3'd0 && len < 300) begin
      ped = (len == 5);
      len++;
      @(negedge clk);
    end
    ped = 1'b0;
    checks++;
    if (len !== 32) begin
      failures++;
      $display("FAIL ped_main_len got=%0d want 32", len);
    end
    run_phase(len);
    run_phase(len);
    checks++;
    if (phase !== 3'd3) begin
      failures++;
      $display("FAIL ped_reach_side phase=%0d want 3", phase);
    end
    len = 0;
    wl = 0;
    while (phase == 3'd3 && len < 300) begin
      if (walk) wl++;
      len++;
      @(negedge clk);
    end
    checks++;
    if (len !== 22 || wl !== 22) begin
      failures++;
      $display("FAIL ped_walk len=%0d walk=%0d want 22/22", len, wl);
    end
    checks++;
    if (dut.ped_pending !== 1'b0) begin
      failures++;
      $display("FAIL ped_cleared got=%b want 0", dut.ped_pending);
    end
    wait_phase(3'd0, len);
    moved = 0;
    for (int i = 0; i < 40; i++) begin
      if (phase != 3'd0) moved++;
      @(negedge clk);
    end
    checks++;
    if (moved !== 0) begin
      failures++;
      $display("FAIL ped_no_retrigger left_cycles=%0d want 0", moved);
    end
  endtask

  task automatic test_ped_on_entry;
    int n;
    int len;
    int wl;
    car = 1'b1;
    @(negedge clk);
    car = 1'b0;
    wait_phase(3'd2, n);
    repeat (3) @(negedge clk);
    ped = 1'b1;
    @(negedge clk);
    ped = 1'b0;
    checks++;
    if (phase !== 3'd3 || walk !== 1'b1) begin
      failures++;
      $display("FAIL entry_press phase=%0d walk=%b want 3/1", phase, walk);
    end
    wl = 0;
    len = 0;
    while (phase == 3'd3 && len < 300) begin
      if (walk) wl++;
      len++;
      @(negedge clk);
    end
    checks++;
    if (wl !== 22) begin
      failures++;
      $display("FAIL entry_press_walk got=%0d want 22", wl);
    end
    wait_phase(3'd0, n);
    run_phase(len);
    checks++;
    if (len !== 32 || phase !== 3'd1) begin
      failures++;
      $display("FAIL retained_pending len=%0d phase=%0d want 32/1", len, phase);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int len;
    ped = 1'b1;
    @(negedge clk);
    ped = 1'b0;
    wait_phase(3'd3, n);
    repeat (12) @(negedge clk);
    checks++;
    if (tcnt !== 7'd9 || walk !== 1'b1) begin
      failures++;
      $display("FAIL mid_precond cnt=%0d walk=%b want 9/1", tcnt, walk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({walk, ml, sl, tload, tval, tdown, phase} !==
        {1'b0, 3'b100, 3'b100, 1'b1, 7'd2, 1'b0, 3'd5}) begin
      failures++;
      $display("FAIL mid_reset walk=%b ml=%b sl=%b ld=%b val=%0d dn=%b ph=%0d",
               walk, ml, sl, tload, tval, tdown, phase);
    end
    @(negedge clk);
    rst = 1'b1;
    run_phase(len);
    checks++;
    if (len !== 4 || phase !== 3'd0) begin
      failures++;
      $display("FAIL mid_resume len=%0d phase=%0d want 4/0", len, phase);
    end
  endtask

  task automatic test_short_params;
    int len;
    int exp_len[7];
    exp_len = '{2, 7, 3, 2, 5, 3, 2};
    checks++;
    if (tcnt2 !== 3'd0 || tload2 !== 1'b1 || tval2 !== 3'd0) begin
      failures++;
      $display("FAIL short_reset cnt=%0d ld=%b val=%0d want 0/1/0", tcnt2, tload2, tval2);
    end
    car2 = 1'b1;
    rst2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_phase2(len);
      checks++;
      if (len !== exp_len[i]) begin
        failures++;
        $display("FAIL short_phase_len idx=%0d got=%0d want %0d", i, len, exp_len[i]);
      end
    end
    car2 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_idle_hold;
    test_car_cycle;
    test_ped_pulse;
    test_ped_on_entry;
    test_reset_mid;
    test_short_params;
    checks++;
    if (unsafe !== 0) begin
      failures++;
      $display("FAIL safety_conflict cycles=%0d want 0", unsafe);
    end
    checks++;
    if (walk_bad !== 0) begin
      failures++;
      $display("FAIL walk_outside_side cycles=%0d want 0", walk_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
